telegram_seq: RTL
=================

Name: telegram_seq

Overview:
Sequencer for the telegram round-trip of the door-handle HIL link. On a start command it assigns a repetition number and hands it to the telegram generator. It then counts bytes returned by the receive buffer and compares the received repetition number against the transmitted one. On mismatch or timeout it retransmits with the same number up to a retry limit, then reports done or error to the host-side logic.

Parameters:
FRAME_LEN, 11, bytes per received telegram (4-bit count, 1..15)
TIMEOUT, 50000, cycles allowed in WAIT_RX before a retry
TMR_W, 16, timer width; must hold TIMEOUT-1
MAX_RETRY, 3, retransmissions allowed after the first attempt

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  request new telegram; sampled in IDLE only
tx_ack  in  1  generator accepted telegram (level, sampled while tx_req=1)
rx_valid  in  1  one-cycle pulse per byte stored by receive buffer
crn  in  8  repetition number decoded by buffer; valid when FRAME_LEN bytes received
tx_req  out  1  request generator to send telegram carrying rn
rn  out  8  current repetition number
buf_clr  out  1  one-cycle clear to receive buffer
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: telegram confirmed
err  out  1  sticky: retries exhausted
retry_cnt  out  2  retransmissions used for current telegram

Behaviour:
- Reset (async, any state): state=IDLE. rn=0, retry_cnt=0, rx_cnt=0, timer=0. All outputs 0.
- States: IDLE, SEND, WAIT_RX, CHECK, RETRY, DONE, FAIL. All outputs registered.
- IDLE: start=1 -> SEND. Same edge: rn<=rn+1 (8-bit wrap, 255->0), retry_cnt<=0, err<=0, buf_clr=1 for one cycle.
- SEND: tx_req=1. On tx_ack=1 -> WAIT_RX. Same edge: tx_req<=0, rx_cnt<=0, timer<=0. No timeout in SEND; the generator must acknowledge.
- WAIT_RX: each rx_valid increments rx_cnt. Reaching rx_cnt==FRAME_LEN -> CHECK. timer increments every cycle; timer==TIMEOUT-1 -> RETRY.
- WAIT_RX, rx_valid completing the frame on the timeout cycle: CHECK wins.
- CHECK (1 cycle): crn==rn -> DONE, else -> RETRY.
- RETRY (1 cycle): if retry_cnt==MAX_RETRY -> FAIL. Else retry_cnt++, buf_clr=1 for one cycle, -> SEND. rn is unchanged.
- DONE: done=1 for one cycle -> IDLE.
- FAIL: err<=1 -> IDLE. err holds until the next accepted start or reset.
- Ignored inputs: start while busy; rx_valid outside WAIT_RX; tx_ack outside SEND.
- Latency, start to tx_req: 1 cycle. Last rx_valid to done: 2 cycles (CHECK, DONE).
- Back-to-back: start high in the cycle after done is accepted (IDLE reached).
- rn is stable from SEND entry until the next accepted start.

Decomposition:
- Shared package telegram_pkg: state enum; FRAME_LEN default 11 (4'b1011); the 8-bit repetition-number type. The telegram generator and receive buffer use the same package.
- One natural sub-module: seq_timer, a TMR_W-bit clearable up-counter with terminal-count flag. The FSM stays in telegram_seq.

Test Plan:
- Clean round-trip: reset, start, tx_ack after 3 cycles, 11 rx_valid pulses, crn=1 -> rn=1, done pulses once 2 cycles after the last byte, err=0, retry_cnt=0.
- Mismatch then match: crn=0 on first frame, crn=1 on second -> exactly one buf_clr in RETRY, tx_req reasserted with rn still 1, retry_cnt=1, then done.
- Timeout exhaustion: TIMEOUT=20, no rx_valid -> 4 tx_req assertions (1 + MAX_RETRY), then err=1, busy=0, done never asserted. Next start clears err and sets rn=2.
- Boundary collision: 11th rx_valid on the same cycle as timer==TIMEOUT-1 with matching crn -> DONE, no retry.
- Wrap and ignore: preload rn=255 via 255 successful runs, then start -> rn=0. start and stray rx_valid while busy change nothing.
- Async reset mid-WAIT_RX after 5 bytes -> all outputs 0 immediately without a clock edge, state IDLE, rn=0.

Source files
------------

// File: rtl/telegram_pkg.sv
// telegram_pkg: shared types and constants for the telegram round-trip blocks.
package telegram_pkg;
  typedef logic [2:0] state_t;
  typedef logic [7:0] rn_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_SEND  = 3'd1;
  localparam state_t S_WAIT  = 3'd2;
  localparam state_t S_CHECK = 3'd3;
  localparam state_t S_RETRY = 3'd4;
  localparam state_t S_DONE  = 3'd5;
  localparam state_t S_FAIL  = 3'd6;
  localparam logic [3:0] FRAME_LEN_DEF = 4'b1011;
endpackage

// File: rtl/seq_timer.sv
// seq_timer: clearable up-counter flagging the last cycle of the receive window.
module seq_timer #(
  parameter int TMR_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam logic [TMR_W-1:0] TC = TMR_W'(TIMEOUT - 1);
  logic [TMR_W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  assign tc_o = cnt_q == TC;
endmodule

// File: rtl/telegram_seq.sv
// telegram_seq: sends a numbered telegram, checks the echoed number, retries on mismatch or timeout.
module telegram_seq
  import telegram_pkg::*;
#(
  parameter logic [3:0] FRAME_LEN = FRAME_LEN_DEF,
  parameter int TIMEOUT   = 50000,
  parameter int TMR_W     = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tx_ack,
  input  logic       rx_valid,
  input  logic [7:0] crn,
  output logic       tx_req,
  output logic [7:0] rn,
  output logic       buf_clr,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] retry_cnt
);
  localparam logic [1:0] MAX  = 2'(MAX_RETRY);
  localparam logic [3:0] LAST = FRAME_LEN - 4'd1;
  state_t state_q, state_d;
  rn_t rn_q;
  logic [1:0] retry_q;
  logic [3:0] rx_cnt_q;
  logic tx_req_q, buf_clr_q, busy_q, done_q, err_q, tc, accept, frame_end;
  assign accept    = state_q == S_IDLE && start;
  assign frame_end = state_q == S_WAIT && rx_valid && rx_cnt_q == LAST;
  seq_timer #(.TMR_W(TMR_W), .TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .clr_i(state_q == S_SEND && tx_ack), .en_i(state_q == S_WAIT), .tc_o(tc)
  );
  // a frame completing on the timeout cycle takes priority over the retry
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_SEND : S_IDLE;
      S_SEND:  state_d = tx_ack ? S_WAIT : S_SEND;
      S_WAIT:  state_d = frame_end ? S_CHECK : tc ? S_RETRY : S_WAIT;
      S_CHECK: state_d = crn == rn_q ? S_DONE : S_RETRY;
      S_RETRY: state_d = retry_q == MAX ? S_FAIL : S_SEND;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rn_q      <= '0;
      retry_q   <= '0;
      rx_cnt_q  <= '0;
      tx_req_q  <= 1'b0;
      buf_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_req_q  <= state_d == S_SEND;
      buf_clr_q <= state_d == S_SEND && state_q != S_SEND;
      busy_q    <= state_d != S_IDLE;
      done_q    <= state_d == S_DONE;
      if (accept) rn_q <= rn_q + 1'b1;
      if (accept) err_q <= 1'b0;
      else if (state_q == S_FAIL) err_q <= 1'b1;
      if (accept) retry_q <= '0;
      else if (state_q == S_RETRY && state_d == S_SEND) retry_q <= retry_q + 1'b1;
      if (state_q == S_SEND && tx_ack) rx_cnt_q <= '0;
      else if (state_q == S_WAIT && rx_valid) rx_cnt_q <= rx_cnt_q + 1'b1;
    end
  end
  assign tx_req    = tx_req_q;
  assign rn        = rn_q;
  assign buf_clr   = buf_clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign retry_cnt = retry_q;
endmodule
